// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sampling front end: sequencer states,
// default conversion timing and the protection thresholds.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    CONV,
    CAPTURE,
    HOLD
  } adc_state_e;

  // Default timing at 100 MHz: 5 us sample period, 4-cycle strobe,
  // 150-cycle conversion time of the external ADC.
  localparam int DEF_PERIOD      = 500;
  localparam int DEF_CONVST_LOW  = 4;
  localparam int DEF_CONV_CYCLES = 150;
  localparam int DEF_AVG_LOG2    = 2;

  // Output-voltage window in ADC codes, shared with the protection logic.
  localparam int OV_THRESH_DEF = 224;
  localparam int UV_THRESH_DEF = 160;

endpackage

// File: rtl/adc_sample_ctrl_mov_avg.sv
// N-deep moving average (N = 2^AVG_LOG2) built from a history shift register
// and a running sum; the output valid is held off until N samples are in.
module mov_avg #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_p0,
  input  logic [DATA_W-1:0] din_p0,
  output logic [DATA_W-1:0] avg,
  output logic              avg_valid
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(N);

  logic [DATA_W-1:0]  hist_p1 [N];
  logic [SUM_W-1:0]   sum_p1;
  logic [SUM_W-1:0]   sum_nxt;
  logic [AVG_LOG2:0]  fill_p1;
  logic [AVG_LOG2:0]  fill_inc;

  // Truncating divide by N.
  function automatic logic [DATA_W-1:0] trunc_avg(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:AVG_LOG2];
  endfunction

  // Running sum update and saturating fill count for the incoming sample.
  always_comb begin
    sum_nxt  = sum_p1 + SUM_W'(din_p0) - SUM_W'(hist_p1[N-1]);
    fill_inc = (fill_p1 == FILL_FULL) ? FILL_FULL : fill_p1 + 1'b1;
  end

  // Stage p0 -> p1: shift history, commit sum, publish average.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) hist_p1[i] <= '0;
      sum_p1    <= '0;
      fill_p1   <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= vld_p0 && (fill_inc == FILL_FULL);
      if (vld_p0) begin
        hist_p1[0] <= din_p0;
        for (int i = 1; i < N; i++) hist_p1[i] <= hist_p1[i-1];
        sum_p1  <= sum_nxt;
        fill_p1 <= fill_inc;
        avg     <= trunc_avg(sum_nxt);
      end
    end
  end

endmodule

// File: rtl/adc_sample_ctrl.sv
// Parallel-ADC sampling controller: periodic conversion strobe, capture after
// the conversion time, per-sample OV/UV flags, sample counter and moving average.
module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PERIOD      = DEF_PERIOD,
  parameter int CONVST_LOW  = DEF_CONVST_LOW,
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int AVG_LOG2    = DEF_AVG_LOG2,
  parameter int OV_THRESH   = OV_THRESH_DEF,
  parameter int UV_THRESH   = UV_THRESH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic              convst_bar,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic [DATA_W-1:0] avg,
  output logic              avg_valid,
  output logic              ov_flag,
  output logic              uv_flag,
  output logic [15:0]       sample_cnt
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(CONVST_LOW - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONVST_LOW + CONV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(PERIOD - 1);
  localparam logic [DATA_W-1:0] OV_T       = DATA_W'(OV_THRESH);
  localparam logic [DATA_W-1:0] UV_T       = DATA_W'(UV_THRESH);

  if (CONVST_LOW < 1 || CONVST_LOW + CONV_CYCLES + 3 > PERIOD) begin : g_bad_cfg
    $error("adc_sample_ctrl: illegal CONVST_LOW/CONV_CYCLES/PERIOD combination");
  end

  adc_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             capture;

  function automatic logic ov_hit(input logic [DATA_W-1:0] d);
    return d > OV_T;
  endfunction

  function automatic logic uv_hit(input logic [DATA_W-1:0] d);
    return d < UV_T;
  endfunction

  // Sequencer next state and period counter; counter parked at 0 in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en) state_nxt = STROBE;
      end
      STROBE:  if (cnt == STROBE_LAST) state_nxt = CONV;
      CONV:    if (cnt == CONV_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = en ? STROBE : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ADC data is captured on the edge that enters CAPTURE.
  assign capture = (state == CONV) && (cnt == CONV_LAST);

  // Sequencer state, counter and registered (glitch-free) strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      convst_bar <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      convst_bar <= (state_nxt != STROBE);
    end
  end

  // Stage p0: sample register, flags and counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      ov_flag      <= 1'b0;
      uv_flag      <= 1'b0;
      sample_cnt   <= '0;
    end else begin
      sample_valid <= capture;
      if (capture) begin
        sample     <= data_in;
        ov_flag    <= ov_hit(data_in);
        uv_flag    <= uv_hit(data_in);
        sample_cnt <= sample_cnt + 16'd1;
      end
    end
  end

  mov_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_mov_avg (
    .clk       (clk),
    .rst       (rst),
    .vld_p0    (sample_valid),
    .din_p0    (sample),
    .avg       (avg),
    .avg_valid (avg_valid)
  );

endmodule

// File: doc/adc_sample_ctrl.md
Name: adc_sample_ctrl

Overview:
Parallel-ADC front-end controller for the multi-phase buck loop. It generates the periodic active-low conversion strobe `convst_bar` for the external 8-bit ADC, waits out the conversion time, and captures `data_in`. It then presents the captured sample, a 2^AVG_LOG2-point moving average, and over/under-voltage flags to the compensator/PWM logic. It sits between the ADC pins and the control datapath inside `top`.

Parameters:
DATA_W, 8, ADC sample width
PERIOD, 500, clk cycles per sample period (5 us at 100 MHz)
CONVST_LOW, 4, cycles `convst_bar` is held low per conversion
CONV_CYCLES, 150, cycles from `convst_bar` rising to data valid at ADC pins
AVG_LOG2, 2, log2 of moving-average depth (N = 4)
OV_THRESH, 224, sample strictly above this raises `ov_flag`
UV_THRESH, 160, sample strictly below this raises `uv_flag`

Ports:
clk, in, 1, system clock
rst, in, 1, reset; synchronous, active-low
en, in, 1, sampling enable
data_in, in, DATA_W, ADC parallel output bus
convst_bar, out, 1, ADC conversion-start strobe, active-low
sample, out, DATA_W, last captured sample
sample_valid, out, 1, 1-cycle pulse when `sample` updates
avg, out, DATA_W, moving average of the last N samples
avg_valid, out, 1, 1-cycle pulse when `avg` updates, only after N samples have been captured
ov_flag, out, 1, over-voltage flag for the last sample
uv_flag, out, 1, under-voltage flag for the last sample
sample_cnt, out, 16, captured-sample counter, wraps at 65535->0

Behaviour:
- Reset (rst=0 at posedge): `convst_bar`=1; `sample`, `avg`, `sample_cnt`=0; `sample_valid`, `avg_valid`, `ov_flag`, `uv_flag`=0. The history shift register, running sum and fill counter are cleared. FSM goes to IDLE. Reset mid-conversion aborts immediately; `convst_bar` is high on the cycle after the reset edge.
- Period counter `cnt` runs 0..PERIOD-1 and is active only outside IDLE.
- FSM states:
  - IDLE: `convst_bar`=1. If en=1, go to STROBE with cnt=0.
  - STROBE: `convst_bar`=0 while cnt < CONVST_LOW, then go to CONV.
  - CONV: wait until cnt == CONVST_LOW+CONV_CYCLES, then go to CAPTURE.
  - CAPTURE (1 cycle): register `data_in` into `sample`, then go to HOLD.
  - HOLD: wait for cnt == PERIOD-1. At that point, if en=1 go to STROBE with cnt=0; otherwise go to IDLE.
- Strobe timing: the first falling edge of `convst_bar` occurs 1 cycle after en is seen high in IDLE. Subsequent falling edges are exactly PERIOD cycles apart.
- `sample_valid` is high on the cycle with cnt == CONVST_LOW+CONV_CYCLES+1. `ov_flag`, `uv_flag` and `sample_cnt` (+1) update on the same edge as `sample`. The flags are per-sample, not sticky.
- Averaging, on the cycle after `sample_valid`:
  - sum += new − oldest, with the N-deep history shifted.
  - sum is DATA_W+AVG_LOG2 bits wide and never overflows.
  - `avg` = sum >> AVG_LOG2 (truncating).
  - `avg_valid` pulses only once the fill count reaches N; the fill count saturates at N.
- en deasserted mid-period: the current conversion, capture and averaging complete. No new strobe is issued, and the block returns to IDLE at cnt == PERIOD-1. History is kept, so re-enabling does not re-fill.
- Legal configuration: CONVST_LOW ≥ 1 and CONVST_LOW+CONV_CYCLES+3 ≤ PERIOD. Behaviour outside this range is undefined and flagged by an elaboration-time check.

Decomposition:
- Package `adc_pkg` holds:
  - the FSM state enum (IDLE, STROBE, CONV, CAPTURE, HOLD);
  - default timing constants;
  - the threshold constants shared with the protection logic.
- One sub-module, `mov_avg`, implements the N-deep shift register, running sum and fill counter, with valid in/out.

Test Plan:
Sim parameters: PERIOD=20, CONVST_LOW=2, CONV_CYCLES=5, AVG_LOG2=2. The ADC model drives a new value on each `convst_bar` falling edge.
- Reset then en=1 → `convst_bar` low for exactly 2 cycles, falling edges 20 cycles apart, `sample_valid` at cnt=8, `avg_valid` at cnt=9.
- Model drives 100, 104, 108, 112, 116 → `avg_valid` first pulses after the 4th sample with `avg`=106, then `avg`=110.
- Samples 225, 224, 159, 160 → `ov_flag` sequence 1,0,0,0 and `uv_flag` sequence 0,0,1,0.
- en dropped at cnt=3 → that sample is still captured (`sample_cnt`+1), no further strobe, FSM returns to IDLE; re-enabling restarts the strobe 1 cycle later with `avg_valid` on the first new sample.
- rst=0 asserted during CONV → next cycle `convst_bar`=1 and all outputs 0; after release, 4 samples are needed before `avg_valid`.
- Preload `sample_cnt` path by running 65536 samples → `sample_cnt` wraps to 0 with no glitch on the other outputs.
